// File: rtl/hls_run_sequencer.sv
// Run controller for one Bambu accelerator: launches back-to-back runs over the
// start_port/done_port handshake, times each run and keeps batch statistics.
module hls_run_sequencer #(
    parameter int unsigned CNT_WIDTH          = 32,
    parameter int unsigned RUNS_WIDTH         = 16,
    parameter int unsigned TIMEOUT_CYCLES     = 200000000,
    parameter int unsigned GAP_CYCLES         = 2,
    parameter int unsigned RESET_BETWEEN_RUNS = 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            go,
    input  logic [RUNS_WIDTH-1:0]           num_runs,
    output logic                            acc_start_port,
    input  logic                            acc_done_port,
    output logic                            acc_reset_n,
    output logic                            busy,
    output logic                            done,
    output logic                            timed_out,
    output logic                            run_valid,
    output logic [RUNS_WIDTH-1:0]           runs_completed,
    output logic [CNT_WIDTH-1:0]            last_cycles,
    output logic [CNT_WIDTH-1:0]            min_cycles,
    output logic [CNT_WIDTH-1:0]            max_cycles,
    output logic [CNT_WIDTH+RUNS_WIDTH-1:0] total_cycles
);
    localparam int unsigned TOT_W = CNT_WIDTH + RUNS_WIDTH;
    localparam int unsigned SUM_W = TOT_W + 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT  = CNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GAP   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic                  w_run_done;
    logic                  w_timeout;
    logic                  w_last_run;
    logic [SUM_W-1:0]      w_sum;
    logic [CNT_WIDTH-1:0]  w_min_new;
    logic [CNT_WIDTH-1:0]  w_max_new;

    logic [GAP_W-1:0]      r_gap;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [RUNS_WIDTH-1:0] r_num;
    logic [RUNS_WIDTH-1:0] r_runs;
    logic [CNT_WIDTH-1:0]  r_last;
    logic [CNT_WIDTH-1:0]  r_min;
    logic [CNT_WIDTH-1:0]  r_max;
    logic [TOT_W-1:0]      r_total;
    logic                  r_start;
    logic                  r_acc_rst_n;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_timed_out;
    logic                  r_run_valid;

    // r_cnt equals the latency of a done arriving in the current WAIT cycle
    assign w_last_run = (r_runs + RUNS_WIDTH'(1)) == r_num;
    assign w_sum      = {1'b0, r_total} + SUM_W'(r_cnt);
    assign w_min_new  = ((r_runs == '0) || (r_cnt < r_min)) ? r_cnt : r_min;
    assign w_max_new  = (r_cnt > r_max) ? r_cnt : r_max;

    // Next-state and per-cycle event decode
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_run_done = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_accept = 1'b1;
                    w_next   = (num_runs == '0) ? S_FIN : S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) w_next = S_START;
            end
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (acc_done_port) begin
                    w_run_done = 1'b1;
                    w_next     = w_last_run ? S_FIN : S_GAP;
                end else if (r_cnt == TIMEOUT) begin
                    w_timeout = 1'b1;
                    w_next    = S_FIN;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, counters, statistics and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_gap       <= '0;
            r_cnt       <= '0;
            r_num       <= '0;
            r_runs      <= '0;
            r_last      <= '0;
            r_min       <= '0;
            r_max       <= '0;
            r_total     <= '0;
            r_start     <= 1'b0;
            r_acc_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
            r_run_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_gap       <= (r_state == S_GAP) ? r_gap + GAP_W'(1) : '0;
            if (w_next == S_START) begin
                r_cnt <= '0;
            end else if ((r_state == S_START) || (r_state == S_WAIT)) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
            r_start     <= (w_next == S_START);
            r_acc_rst_n <= !((w_next == S_GAP) && (RESET_BETWEEN_RUNS != 0));
            r_busy      <= (w_next != S_IDLE);
            r_done      <= (w_next == S_FIN);
            r_run_valid <= w_run_done;
            if (w_accept) begin
                r_num       <= num_runs;
                r_runs      <= '0;
                r_last      <= '0;
                r_min       <= '0;
                r_max       <= '0;
                r_total     <= '0;
                r_timed_out <= 1'b0;
            end
            if (w_run_done) begin
                r_runs  <= r_runs + RUNS_WIDTH'(1);
                r_last  <= r_cnt;
                r_min   <= w_min_new;
                r_max   <= w_max_new;
                r_total <= w_sum[TOT_W] ? {TOT_W{1'b1}} : w_sum[TOT_W-1:0];
            end
            if (w_timeout) r_timed_out <= 1'b1;
        end
    end

    assign acc_start_port = r_start;
    assign acc_reset_n    = r_acc_rst_n;
    assign busy           = r_busy;
    assign done           = r_done;
    assign timed_out      = r_timed_out;
    assign run_valid      = r_run_valid;
    assign runs_completed = r_runs;
    assign last_cycles    = r_last;
    assign min_cycles     = r_min;
    assign max_cycles     = r_max;
    assign total_cycles   = r_total;
endmodule

// File: tb/tb_hls_run_sequencer.sv
// Bench for hls_run_sequencer: behavioural accelerator responder plus a batch-level
// model of latencies, statistics and done timing; two DUTs differ only in inter-run reset.
module tb_hls_run_sequencer;
    localparam int CW = 32;
    localparam int RW = 16;
    localparam int TW = CW + RW;
    localparam int T  = 20;
    localparam int G  = 2;

    logic          clock      = 1'b0;
    logic          reset      = 1'b0;
    logic          go         = 1'b0;
    logic [RW-1:0] num_runs   = '0;
    logic          resp_done  = 1'b0;
    logic          force_done = 1'b0;
    logic          acc_done_port;
    assign acc_done_port = resp_done | force_done;

    logic a_start, a_rst_n, a_busy, a_done, a_to, a_rv;
    logic [RW-1:0] a_runs;
    logic [CW-1:0] a_last, a_min, a_max;
    logic [TW-1:0] a_total;
    logic n_start, n_rst_n, n_busy, n_done, n_to, n_rv;
    logic [RW-1:0] n_runs;
    logic [CW-1:0] n_last, n_min, n_max;
    logic [TW-1:0] n_total;

    hls_run_sequencer #(.CNT_WIDTH(CW), .RUNS_WIDTH(RW), .TIMEOUT_CYCLES(T),
                        .GAP_CYCLES(G), .RESET_BETWEEN_RUNS(1)) u_dut (
        .clock(clock), .reset(reset), .go(go), .num_runs(num_runs),
        .acc_start_port(a_start), .acc_done_port(acc_done_port), .acc_reset_n(a_rst_n),
        .busy(a_busy), .done(a_done), .timed_out(a_to), .run_valid(a_rv),
        .runs_completed(a_runs), .last_cycles(a_last), .min_cycles(a_min),
        .max_cycles(a_max), .total_cycles(a_total));

    hls_run_sequencer #(.CNT_WIDTH(CW), .RUNS_WIDTH(RW), .TIMEOUT_CYCLES(T),
                        .GAP_CYCLES(G), .RESET_BETWEEN_RUNS(0)) u_dut_nr (
        .clock(clock), .reset(reset), .go(go), .num_runs(num_runs),
        .acc_start_port(n_start), .acc_done_port(acc_done_port), .acc_reset_n(n_rst_n),
        .busy(n_busy), .done(n_done), .timed_out(n_to), .run_valid(n_rv),
        .runs_completed(n_runs), .last_cycles(n_last), .min_cycles(n_min),
        .max_cycles(n_max), .total_cycles(n_total));

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    logic reset_q = 1'b0;
    always @(posedge clock) begin
        cyc     <= cyc + 1;
        reset_q <= reset;
    end

    // Event monitors sampled mid-cycle
    int   start_hi = 0, start_rise = 0, rv_cnt = 0, done_cnt = 0;
    int   gap_ok = 0, gap_bad = 0, nr_low = 0, low_run = 0;
    logic start_prev = 1'b0;
    int   obs_lat[$];
    always @(negedge clock) begin
        if (a_start) begin
            start_hi++;
            if (!start_prev) start_rise++;
            if (low_run == G) gap_ok++;
            else gap_bad++;
        end
        start_prev = a_start;
        low_run    = a_rst_n ? 0 : low_run + 1;
        if (a_rv) begin
            rv_cnt++;
            obs_lat.push_back(int'(a_last));
        end
        if (a_done) done_cnt++;
        if (reset_q && !n_rst_n) nr_low++;
    end

    // Accelerator: latency 0 means it never completes; a reset abandons the run
    int cur_lats [0:7];
    int resp_l;
    bit resp_ab;
    always begin
        @(negedge clock);
        if (a_start) begin
            resp_l  = cur_lats[a_runs[2:0]];
            resp_ab = 1'b0;
            if (resp_l > 0) begin
                for (int k = 0; k < resp_l && !resp_ab; k++) begin
                    @(posedge clock);
                    if (!reset) resp_ab = 1'b1;
                end
                if (!resp_ab) begin
                    #1 resp_done = 1'b1;
                    @(posedge clock);
                    #1 resp_done = 1'b0;
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_lats(input int l0, input int l1, input int l2, input int l3);
        cur_lats[0] = l0; cur_lats[1] = l1; cur_lats[2] = l2; cur_lats[3] = l3;
    endtask

    task automatic run_batch(input string name, input int n, input bit hold_go,
                             input bit stale, input bit pre);
        int  done_runs = 0;
        bit  exp_to = 0;
        longint sum = 0;
        int  mn = 0, mx = 0, last = 0, exp_off = 1, starts;
        int  c0, bound, s_hi, s_rise, s_rv, s_done, s_ok, s_bad, s_nr, obs_base;
        for (int i = 0; i < n; i++) begin
            if (!exp_to) begin
                if (cur_lats[i] == 0 || cur_lats[i] > T) begin
                    exp_to  = 1;
                    exp_off += G + 1 + T;
                end else begin
                    done_runs++;
                    sum += cur_lats[i];
                    if (done_runs == 1 || cur_lats[i] < mn) mn = cur_lats[i];
                    if (cur_lats[i] > mx) mx = cur_lats[i];
                    last = cur_lats[i];
                    exp_off += G + 1 + cur_lats[i];
                end
            end
        end
        starts = done_runs + int'(exp_to);
        s_hi = start_hi; s_rise = start_rise; s_rv = rv_cnt; s_done = done_cnt;
        s_ok = gap_ok; s_bad = gap_bad; s_nr = nr_low; obs_base = obs_lat.size();
        if (pre) begin
            c0 = int'(cyc) - 1;
        end else begin
            num_runs   = RW'(n);
            go         = 1'b1;
            force_done = stale;
            c0         = int'(cyc);
            step();
            if (!hold_go) go = 1'b0;
        end
        bound = exp_off + 40;
        while (!a_done && (int'(cyc) - c0) < bound) begin
            if (int'(cyc) - c0 == G + 2) force_done = 1'b0;
            step();
        end
        force_done = 1'b0;
        chk({name, "/done_offset"}, 64'(int'(cyc) - c0), 64'(exp_off));
        chk({name, "/busy_at_done"}, 64'(a_busy), 64'd1);
        chk({name, "/timed_out"}, 64'(a_to), 64'(exp_to));
        chk({name, "/runs"}, 64'(a_runs), 64'(done_runs));
        chk({name, "/last"}, 64'(a_last), 64'(last));
        chk({name, "/min"}, 64'(a_min), 64'(mn));
        chk({name, "/max"}, 64'(a_max), 64'(mx));
        chk({name, "/total"}, 64'(a_total), 64'(sum));
        chk({name, "/nr_total"}, 64'(n_total), 64'(sum));
        chk({name, "/nr_runs"}, 64'(n_runs), 64'(done_runs));
        step();
        chk({name, "/done_after"}, 64'(a_done), 64'd0);
        chk({name, "/busy_after"}, 64'(a_busy), 64'd0);
        chk({name, "/done_pulses"}, 64'(done_cnt - s_done), 64'd1);
        chk({name, "/start_pulses"}, 64'(start_rise - s_rise), 64'(starts));
        chk({name, "/start_cycles"}, 64'(start_hi - s_hi), 64'(starts));
        chk({name, "/run_valids"}, 64'(rv_cnt - s_rv), 64'(done_runs));
        chk({name, "/gap_reset_ok"}, 64'(gap_ok - s_ok), 64'(starts));
        chk({name, "/gap_reset_bad"}, 64'(gap_bad - s_bad), 64'd0);
        chk({name, "/nr_reset_low"}, 64'(nr_low - s_nr), 64'd0);
        chk({name, "/lat_count"}, 64'(obs_lat.size() - obs_base), 64'(done_runs));
        for (int i = 0; i < done_runs && obs_base + i < obs_lat.size(); i++)
            chk({name, "/lat"}, 64'(obs_lat[obs_base + i]), 64'(cur_lats[i]));
    endtask

    int k;
    int s0;
    int sd;
    int rn;
    initial begin
        // Reset state
        repeat (3) step();
        chk("rst/start", 64'(a_start), 64'd0);
        chk("rst/acc_reset_n", 64'(a_rst_n), 64'd0);
        chk("rst/busy", 64'(a_busy), 64'd0);
        chk("rst/done", 64'(a_done), 64'd0);
        chk("rst/timed_out", 64'(a_to), 64'd0);
        chk("rst/total", 64'(a_total), 64'd0);
        reset = 1'b1;
        step();
        chk("idle/acc_reset_n", 64'(a_rst_n), 64'd1);
        chk("idle/nr_acc_reset_n", 64'(n_rst_n), 64'd1);

        set_lats(10, 0, 0, 0);  run_batch("single", 1, 0, 0, 0);
        set_lats(5, 12, 7, 0);  run_batch("multi", 3, 0, 0, 0);
        set_lats(0, 5, 0, 0);   run_batch("timeout", 2, 0, 0, 0);
        set_lats(0, 0, 0, 0);   run_batch("zero_runs", 0, 0, 0, 0);
        set_lats(20, 0, 0, 0);  run_batch("done_at_timeout", 1, 0, 0, 0);
        set_lats(4, 9, 0, 0);   run_batch("stale_done", 2, 0, 1, 0);

        // Reset in the middle of run 2 of 4
        set_lats(6, 15, 5, 5);
        num_runs = RW'(4);
        go = 1'b1;
        s0 = start_rise;
        sd = done_cnt;
        step();
        go = 1'b0;
        k = 0;
        while (start_rise - s0 < 2 && k < 100) begin
            step();
            k++;
        end
        chk("midrst/second_start", 64'(start_rise - s0), 64'd2);
        repeat (3) step();
        chk("midrst/runs_before", 64'(a_runs), 64'd1);
        reset = 1'b0;
        step();
        chk("midrst/start", 64'(a_start), 64'd0);
        chk("midrst/acc_reset_n", 64'(a_rst_n), 64'd0);
        chk("midrst/busy", 64'(a_busy), 64'd0);
        chk("midrst/done", 64'(a_done), 64'd0);
        chk("midrst/run_valid", 64'(a_rv), 64'd0);
        chk("midrst/runs", 64'(a_runs), 64'd0);
        chk("midrst/last", 64'(a_last), 64'd0);
        chk("midrst/min", 64'(a_min), 64'd0);
        chk("midrst/max", 64'(a_max), 64'd0);
        chk("midrst/total", 64'(a_total), 64'd0);
        reset = 1'b1;
        step();
        chk("midrst/acc_reset_n_after", 64'(a_rst_n), 64'd1);
        repeat (25) step();
        chk("midrst/no_done", 64'(done_cnt - sd), 64'd0);
        chk("midrst/still_idle", 64'(a_busy), 64'd0);
        set_lats(8, 3, 17, 1);  run_batch("after_reset", 4, 0, 0, 0);

        // go held high across a batch; the next batch starts after the IDLE cycle
        set_lats(3, 8, 0, 0);   run_batch("hold_go", 2, 1, 0, 0);
        num_runs = RW'(2);
        set_lats(6, 2, 0, 0);
        step();
        chk("hold_go2/busy", 64'(a_busy), 64'd1);
        chk("hold_go2/runs_cleared", 64'(a_runs), 64'd0);
        chk("hold_go2/total_cleared", 64'(a_total), 64'd0);
        chk("hold_go2/last_cleared", 64'(a_last), 64'd0);
        go = 1'b0;
        run_batch("hold_go2", 2, 0, 0, 1);

        // Randomized batches
        for (int b = 0; b < 6; b++) begin
            rn = int'($urandom_range(1, 4));
            for (int i = 0; i < 4; i++)
                cur_lats[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, T));
            run_batch("random", rn, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
